bus_keeper_decay_m: RTL and testbench



---
 rtl/bus_keeper_decay_m.sv | 135 +++++++++++++
 tb/tb_bus_keeper_decay_m.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_keeper_decay_m.sv
// ---------------------------------------------------------------------------
// bus_keeper_decay_m
//
// Clocked bus keeper for a multi-bit tri-state bus in a simulation model.
// While no strong driver owns the bus, the keeper weakly drives the last value
// it captured. After DECAY_CYCLES undriven clock edges the kept value relaxes
// to DECAY_VAL, which models charge leakage. DECAY_CYCLES = 0 disables decay
// and the value is held forever. Driver contention is also flagged: this is an
// X or Z bit seen while the bus was strongly driven.
//
// Parameters
//   WIDTH         bus width in bits (>= 1)
//   DECAY_CYCLES  undriven edges before decay; 0 = never decay
//   DECAY_VAL     value the bus relaxes to after decay
//   RESET_VAL     kept value after reset
//   CNT_W         float-age counter width (derived)
//
// Ports
//   clk         clock
//   rst_n       asynchronous reset, active low
//   bus         kept bus; driven by this block only at weak strength
//   driven      1 = a strong driver owns the bus this cycle
//   held        value currently kept / weakly driven
//   decayed     1 = held has relaxed to DECAY_VAL
//   contention  last driven sample contained an X or Z bit
//   float_age   undriven edges since release, saturating
// ---------------------------------------------------------------------------
module bus_keeper_decay_m #(
  parameter int               WIDTH        = 8,
  parameter int               DECAY_CYCLES = 0,
  parameter logic [WIDTH-1:0] DECAY_VAL    = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] RESET_VAL    = {WIDTH{1'b0}},
  parameter int               CNT_W        = $clog2(DECAY_CYCLES + 2)
) (
  input  logic             clk,
  input  logic             rst_n,
  inout  wire  [WIDTH-1:0] bus,
  input  logic             driven,
  output logic [WIDTH-1:0] held,
  output logic             decayed,
  output logic             contention,
  output logic [CNT_W-1:0] float_age
);

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_DRIVEN  = 2'd1,
    ST_DECAYED = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] AGE_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] DECAY_AGE = CNT_W'(DECAY_CYCLES);
  localparam bit               DECAY_EN  = (DECAY_CYCLES != 0);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] held_q, held_d;
  logic             cont_q, cont_d;
  logic [CNT_W-1:0] age_q, age_d;

  logic [WIDTH-1:0] bit_known;
  logic [WIDTH-1:0] captured;
  logic [CNT_W-1:0] age_inc;
  logic             decay_hit;

  // Per-bit capture. A bit XORed with itself is 0 only when that bit is a
  // clean 0 or 1. An X or Z bit gives X, and that bit keeps its old value.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign bit_known[gi] = ((bus[gi] ^ bus[gi]) === 1'b0);
      assign captured[gi]  = bit_known[gi] ? bus[gi] : held_q[gi];
    end
  endgenerate

  // The age counter saturates at all-ones and never wraps.
  assign age_inc = (age_q == AGE_MAX) ? age_q : (age_q + CNT_W'(1));

  // The counter is wide enough to reach DECAY_CYCLES before it saturates.
  // Because of that, the equality below fires exactly once per float.
  assign decay_hit = DECAY_EN && (age_inc == DECAY_AGE) && (state_q != ST_DECAYED);

  always_comb begin
    state_d = state_q;
    held_d  = held_q;
    cont_d  = cont_q;
    age_d   = age_q;

    if (driven) begin
      // A strong driver wins over any decay that would happen on this edge.
      state_d = ST_DRIVEN;
      held_d  = captured;
      cont_d  = ~(&bit_known);
      age_d   = '0;
    end else begin
      age_d = age_inc;
      case (state_q)
        ST_DECAYED: begin
          state_d = ST_DECAYED;
        end
        default: begin
          if (decay_hit) begin
            state_d = ST_DECAYED;
            held_d  = DECAY_VAL;
          end else begin
            state_d = ST_HOLD;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_HOLD;
      held_q  <= RESET_VAL;
      cont_q  <= 1'b0;
      age_q   <= '0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
      cont_q  <= cont_d;
      age_q   <= age_d;
    end
  end

  assign held       = held_q;
  assign decayed    = (state_q == ST_DECAYED);
  assign contention = cont_q;
  assign float_age  = age_q;

  // Weak keeper drive. It releases as soon as driven rises, and the held value
  // falls through with no delay when driven drops.
  assign (weak1, weak0) bus = driven ? {WIDTH{1'bz}} : held_q;

endmodule

// File: tb/tb_bus_keeper_decay_m.sv
// ---------------------------------------------------------------------------
// tb_bus_keeper_decay_m
//
// Scoreboard bench for bus_keeper_decay_m (WIDTH=8, DECAY_CYCLES=4,
// DECAY_VAL=8'hFF, RESET_VAL=8'h00). On each rising edge a reference model
// works out the outputs it expects after that edge and pushes them to a queue.
// The entry is popped and compared 1 time unit later.
// ---------------------------------------------------------------------------
module tb_bus_keeper_decay_m;

  localparam int WIDTH = 8;
  localparam int DECAY = 4;
  localparam int CNT_W = $clog2(DECAY + 2);
  localparam logic [WIDTH-1:0] DVAL = 8'hFF;
  localparam logic [WIDTH-1:0] RVAL = 8'h00;

  logic             clk;
  logic             rst_n;
  logic             driven;
  logic             drv_a_en, drv_b_en;
  logic [WIDTH-1:0] drv_a, drv_b;
  wire  [WIDTH-1:0] bus;
  logic [WIDTH-1:0] held;
  logic             decayed;
  logic             contention;
  logic [CNT_W-1:0] float_age;

  // Strong external drivers.
  assign bus = drv_a_en ? drv_a : {WIDTH{1'bz}};
  assign bus = drv_b_en ? drv_b : {WIDTH{1'bz}};

  bus_keeper_decay_m #(
    .WIDTH       (WIDTH),
    .DECAY_CYCLES(DECAY),
    .DECAY_VAL   (DVAL),
    .RESET_VAL   (RVAL)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .driven    (driven),
    .held      (held),
    .decayed   (decayed),
    .contention(contention),
    .float_age (float_age)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] held;
    logic             dec;
    logic             cont;
    logic [CNT_W-1:0] age;
  } exp_t;

  exp_t sb_q[$];

  // Reference model state
  logic [WIDTH-1:0] m_held;
  logic             m_dec;
  logic             m_cont;
  int               m_age;

  int n_tests;
  int n_fail;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_held = RVAL;
    m_dec  = 1'b0;
    m_cont = 1'b0;
    m_age  = 0;
  endtask

  // Advance one rising edge: update the model from the sampled bus, push the
  // expected state, then pop it and compare against the DUT.
  task automatic cycle(input string tag);
    exp_t e;
    exp_t o;
    logic [WIDTH-1:0] s;
    logic unk;
    @(posedge clk);
    s = bus;
    if (driven) begin
      unk = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        if ($isunknown(s[i])) unk = 1'b1;
        else m_held[i] = s[i];
      end
      m_cont = unk;
      m_age  = 0;
      m_dec  = 1'b0;
    end else begin
      if (m_age < (1 << CNT_W) - 1) m_age++;
      if (!m_dec && m_age == DECAY) begin
        m_dec  = 1'b1;
        m_held = DVAL;
      end
    end
    e.held = m_held;
    e.dec  = m_dec;
    e.cont = m_cont;
    e.age  = CNT_W'(m_age);
    sb_q.push_back(e);
    #1;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      o = sb_q.pop_front();
      check({tag, "_held"}, 32'(held), 32'(o.held));
      check({tag, "_decayed"}, 32'(decayed), 32'(o.dec));
      check({tag, "_contention"}, 32'(contention), 32'(o.cont));
      check({tag, "_age"}, 32'(float_age), 32'(o.age));
      $display("[TB] %s: held=%h decayed=%0b contention=%0b age=%0d", tag, held, decayed,
               contention, float_age);
    end
  endtask

  task automatic drive(input logic [WIDTH-1:0] v);
    drv_a    = v;
    drv_a_en = 1'b1;
    drv_b_en = 1'b0;
    driven   = 1'b1;
  endtask

  task automatic release_bus();
    drv_a_en = 1'b0;
    drv_b_en = 1'b0;
    driven   = 1'b0;
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    drv_a    = '0;
    drv_b    = '0;
    drv_a_en = 1'b0;
    drv_b_en = 1'b0;
    driven   = 1'b0;
    rst_n    = 1'b0;
    model_reset();

    // Reset then float
    #2;
    check("rst_bus", 32'(bus), 32'(RVAL));
    check("rst_held", 32'(held), 32'(RVAL));
    check("rst_decayed", 32'(decayed), 32'd0);
    check("rst_age", 32'(float_age), 32'd0);
    check("rst_contention", 32'(contention), 32'd0);
    rst_n = 1'b1;

    // Drive / hold
    drive(8'hA5);
    cycle("drv_a5");
    release_bus();
    #1;
    check("keep_bus_a5", 32'(bus), 32'h0000_00A5);
    cycle("hold_a5_1");
    drive(8'h3C);
    #1;
    check("override_bus_3c", 32'(bus), 32'h0000_003C);
    cycle("drv_3c");
    release_bus();

    // Decay after 4 undriven edges, then saturate the age counter
    drive(8'h12);
    cycle("drv_12");
    release_bus();
    for (int i = 1; i <= 8; i++) cycle($sformatf("float_%0d", i));
    #1;
    check("decay_bus", 32'(bus), 32'(DVAL));
    drive(8'h00);
    cycle("redrive_00");
    release_bus();

    // Race: re-drive on the edge that would have decayed
    for (int i = 1; i <= 3; i++) cycle($sformatf("race_float_%0d", i));
    drive(8'h55);
    cycle("race_drv_55");
    release_bus();
    cycle("race_after");

    // Contention: two strong drivers disagree on bits 3:0
    drive(8'hF0);
    cycle("pre_cont_f0");
    drv_a    = 8'h0F;
    drv_b    = 8'h00;
    drv_a_en = 1'b1;
    drv_b_en = 1'b1;
    driven   = 1'b1;
    cycle("contend");
    release_bus();
    cycle("cont_hold");
    drive(8'h77);
    cycle("clean_77");
    release_bus();

    // Async reset mid-float
    drive(8'hA5);
    cycle("drv_a5_b");
    release_bus();
    cycle("mid_float_1");
    cycle("mid_float_2");
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("arst_held", 32'(held), 32'(RVAL));
    check("arst_age", 32'(float_age), 32'd0);
    check("arst_bus", 32'(bus), 32'(RVAL));
    check("arst_decayed", 32'(decayed), 32'd0);
    rst_n = 1'b1;
    cycle("post_arst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog so the run always ends by itself.
  initial begin
    #20000;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
